// File: rtl/cache_ctrl.sv
// cache_ctrl: controller for a direct-mapped, 64-line, 64-bit-line data cache.
// Serves CPU word reads/writes, writes dirty victims back to memory and fills
// misses from the other core's cache (snoop) or from memory.
module cache_ctrl #(
  parameter int unsigned HIT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          cpu_addr,
  input  logic                 cpu_re,
  input  logic                 cpu_we,
  input  logic [15:0]          cpu_wdata,
  output logic [15:0]          cpu_rdata,
  output logic                 cpu_done,
  output logic                 cpu_stall,
  output logic [10:0]          c_addr,
  output logic                 c_re,
  output logic                 c_we,
  output logic [63:0]          c_wr_data,
  output logic                 c_wdirty,
  input  logic                 c_hit,
  input  logic                 c_dirty,
  input  logic [63:0]          c_rd_data,
  input  logic [4:0]           c_tag,
  output logic                 snp_req,
  output logic [10:0]          snp_addr,
  input  logic                 snp_found,
  input  logic [63:0]          snp_line,
  output logic [10:0]          mem_addr,
  output logic                 mem_re,
  output logic                 mem_we,
  output logic [63:0]          mem_wdata,
  input  logic [63:0]          mem_rdata,
  input  logic                 mem_rdy,
  output logic [HIT_CNT_W-1:0] hit_cnt,
  output logic [HIT_CNT_W-1:0] miss_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITE,
    EVICT,
    SNOOP,
    FILL,
    INSTALL
  } state_t;

  state_t state;
  state_t state_nxt;

  // Latched request
  logic [10:0] req_line;
  logic [1:0]  req_off;
  logic        req_we;
  logic [15:0] req_wdata;

  // Working line: merged write line, then victim line, then fill line
  logic [63:0] line_buf;
  logic [4:0]  vic_tag;
  logic        from_snp;

  // Address bits above the line address are not decoded
  logic unused_addr;
  assign unused_addr = &{1'b0, cpu_addr[15:13]};

  function automatic logic [15:0] get_word(input logic [63:0] line,
                                           input logic [1:0]  off);
    logic [15:0] w;
    case (off)
      2'd0:    w = line[15:0];
      2'd1:    w = line[31:16];
      2'd2:    w = line[47:32];
      default: w = line[63:48];
    endcase
    return w;
  endfunction

  function automatic logic [63:0] put_word(input logic [63:0] line,
                                           input logic [1:0]  off,
                                           input logic [15:0] w);
    logic [63:0] r;
    r = line;
    case (off)
      2'd0:    r[15:0]  = w;
      2'd1:    r[31:16] = w;
      2'd2:    r[47:32] = w;
      default: r[63:48] = w;
    endcase
    return r;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and array/snoop/memory pin drive
  always_comb begin
    state_nxt = state;
    cpu_stall = 1'b0;
    c_addr    = '0;
    c_re      = 1'b0;
    c_we      = 1'b0;
    c_wr_data = '0;
    c_wdirty  = 1'b0;
    snp_req   = 1'b0;
    snp_addr  = '0;
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;

    if (state != IDLE) begin
      cpu_stall = 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (cpu_re || cpu_we) begin
          state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        c_re   = 1'b1;
        c_addr = req_line;
        if (c_hit) begin
          state_nxt = req_we ? WRITE : IDLE;
        end else if (c_dirty) begin
          state_nxt = EVICT;
        end else begin
          state_nxt = SNOOP;
        end
      end
      WRITE: begin
        c_we      = 1'b1;
        c_addr    = req_line;
        c_wr_data = line_buf;
        c_wdirty  = 1'b1;
        state_nxt = IDLE;
      end
      EVICT: begin
        mem_we    = 1'b1;
        mem_addr  = {vic_tag, req_line[5:0]};
        mem_wdata = line_buf;
        if (mem_rdy) begin
          state_nxt = SNOOP;
        end
      end
      SNOOP: begin
        snp_req   = 1'b1;
        snp_addr  = req_line;
        state_nxt = snp_found ? INSTALL : FILL;
      end
      FILL: begin
        mem_re   = 1'b1;
        mem_addr = req_line;
        if (mem_rdy) begin
          state_nxt = INSTALL;
        end
      end
      INSTALL: begin
        c_we      = 1'b1;
        c_addr    = req_line;
        c_wr_data = req_we ? put_word(line_buf, req_off, req_wdata) : line_buf;
        c_wdirty  = req_we | from_snp;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request latch, line buffer, CPU response and statistics counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_line  <= '0;
      req_off   <= '0;
      req_we    <= 1'b0;
      req_wdata <= '0;
      line_buf  <= '0;
      vic_tag   <= '0;
      from_snp  <= 1'b0;
      cpu_rdata <= '0;
      cpu_done  <= 1'b0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      cpu_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_re || cpu_we) begin
            req_line  <= cpu_addr[12:2];
            req_off   <= cpu_addr[1:0];
            req_we    <= cpu_we;
            req_wdata <= cpu_wdata;
            from_snp  <= 1'b0;
          end
        end
        LOOKUP: begin
          if (c_hit) begin
            if (hit_cnt != '1) begin
              hit_cnt <= hit_cnt + HIT_CNT_W'(1);
            end
            if (req_we) begin
              line_buf <= put_word(c_rd_data, req_off, req_wdata);
            end else begin
              cpu_rdata <= get_word(c_rd_data, req_off);
              cpu_done  <= 1'b1;
            end
          end else begin
            if (miss_cnt != '1) begin
              miss_cnt <= miss_cnt + HIT_CNT_W'(1);
            end
            if (c_dirty) begin
              line_buf <= c_rd_data;
              vic_tag  <= c_tag;
            end
          end
        end
        WRITE: begin
          cpu_done <= 1'b1;
        end
        EVICT: begin
        end
        SNOOP: begin
          if (snp_found) begin
            line_buf <= snp_line;
            from_snp <= 1'b1;
          end
        end
        FILL: begin
          if (mem_rdy) begin
            line_buf <= mem_rdata;
          end
        end
        INSTALL: begin
          cpu_done <= 1'b1;
          if (!req_we) begin
            cpu_rdata <= get_word(line_buf, req_off);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: self-checking bench for cache_ctrl. Surrounds the controller
// with a cache array, the other core's cache and a variable-latency memory,
// and predicts each transaction's visible effects from the cache rules.
module tb_cache_ctrl;

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CMAX = '1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   cpu_addr;
  logic          cpu_re;
  logic          cpu_we;
  logic [15:0]   cpu_wdata;
  logic [15:0]   cpu_rdata;
  logic          cpu_done;
  logic          cpu_stall;
  logic [10:0]   c_addr;
  logic          c_re;
  logic          c_we;
  logic [63:0]   c_wr_data;
  logic          c_wdirty;
  logic          c_hit;
  logic          c_dirty;
  logic [63:0]   c_rd_data;
  logic [4:0]    c_tag;
  logic          snp_req;
  logic [10:0]   snp_addr;
  logic          snp_found;
  logic [63:0]   snp_line;
  logic [10:0]   mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [63:0]   mem_wdata;
  logic [63:0]   mem_rdata;
  logic          mem_rdy;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;

  cache_ctrl #(.HIT_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .c_addr(c_addr), .c_re(c_re), .c_we(c_we), .c_wr_data(c_wr_data),
    .c_wdirty(c_wdirty), .c_hit(c_hit), .c_dirty(c_dirty), .c_rd_data(c_rd_data),
    .c_tag(c_tag), .snp_req(snp_req), .snp_addr(snp_addr), .snp_found(snp_found),
    .snp_line(snp_line), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  // ---------------- environment: cache array ----------------
  logic        arr_valid[64];
  logic        arr_dirty[64];
  logic [4:0]  arr_tag[64];
  logic [63:0] arr_data[64];

  assign c_hit     = arr_valid[c_addr[5:0]] && (arr_tag[c_addr[5:0]] == c_addr[10:6]);
  assign c_dirty   = arr_valid[c_addr[5:0]] && arr_dirty[c_addr[5:0]];
  assign c_rd_data = arr_data[c_addr[5:0]];
  assign c_tag     = arr_tag[c_addr[5:0]];

  initial begin
    for (int i = 0; i < 64; i++) begin
      arr_valid[i] = 1'b0;
      arr_dirty[i] = 1'b0;
      arr_tag[i]   = '0;
      arr_data[i]  = '0;
    end
    forever begin
      @(negedge clk);
      if (rst_n && c_we) begin
        arr_valid[c_addr[5:0]] = 1'b1;
        arr_dirty[c_addr[5:0]] = c_wdirty;
        arr_tag[c_addr[5:0]]   = c_addr[10:6];
        arr_data[c_addr[5:0]]  = c_wr_data;
      end
    end
  end

  // ---------------- environment: other core's cache ----------------
  logic        snp_en;
  logic [63:0] snp_val;
  assign snp_found = snp_en;
  assign snp_line  = snp_val;

  // ---------------- environment: memory with random latency ----------------
  logic [63:0] mem[2048];
  initial begin
    bit busy;
    int cnt;
    for (int i = 0; i < 2048; i++) mem[i] = {$urandom, $urandom};
    mem[11'h041] = 64'h1111_2222_3333_4444;
    mem_rdy   = 1'b0;
    mem_rdata = '0;
    busy      = 1'b0;
    cnt       = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_rdy   = 1'b0;
      mem_rdata = {$urandom, $urandom};
      if (mem_re || mem_we) begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = int'($urandom_range(1, 4));
        end
        cnt--;
        if (cnt == 0) begin
          busy    = 1'b0;
          mem_rdy = 1'b1;
          if (mem_we) mem[mem_addr] = mem_wdata;
          else        mem_rdata = mem[mem_addr];
        end
      end else begin
        busy = 1'b0;
        if ($urandom_range(0, 7) == 0) mem_rdy = 1'b1;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [CW-1:0] m_hit;
  logic [CW-1:0] m_miss;
  logic [10:0]   exp_line;
  logic          exp_hit;
  logic          exp_read;
  logic          exp_evict;
  logic [10:0]   exp_ev_addr;
  logic [63:0]   exp_ev_data;
  logic          exp_from_snp;
  logic [63:0]   exp_wdata;
  logic          exp_dirty;
  logic [15:0]   exp_rdata;
  int unsigned   exp_lat;
  int unsigned   t0;
  int unsigned   n_issued = 0;
  int unsigned   n_done = 0;
  int unsigned   n_aband = 0;

  function automatic logic [15:0] word_of(input logic [63:0] ln, input logic [1:0] off);
    return 16'(ln >> (16 * int'(off)));
  endfunction

  function automatic logic [63:0] with_word(input logic [63:0] ln, input logic [1:0] off,
                                            input logic [15:0] w);
    int sh;
    sh = 16 * int'(off);
    return (ln & ~(64'hFFFF << sh)) | (64'(w) << sh);
  endfunction

  task automatic predict(input logic [15:0] a, input logic w, input logic [15:0] wd);
    logic [5:0]  idx;
    logic [4:0]  tag;
    logic [1:0]  off;
    logic [63:0] ln;
    idx = a[7:2];
    tag = a[12:8];
    off = a[1:0];
    exp_line     = a[12:2];
    exp_read     = !w;
    exp_evict    = 1'b0;
    exp_from_snp = 1'b0;
    exp_lat      = 0;
    exp_hit      = arr_valid[idx] && (arr_tag[idx] == tag);
    if (exp_hit) begin
      if (m_hit != CMAX) m_hit = m_hit + CW'(1);
      ln = arr_data[idx];
      exp_rdata = word_of(ln, off);
      exp_wdata = w ? with_word(ln, off, wd) : ln;
      exp_dirty = 1'b1;
      exp_lat   = w ? 3 : 2;
    end else begin
      if (m_miss != CMAX) m_miss = m_miss + CW'(1);
      if (arr_valid[idx] && arr_dirty[idx]) begin
        exp_evict   = 1'b1;
        exp_ev_addr = {arr_tag[idx], idx};
        exp_ev_data = arr_data[idx];
      end
      if (snp_en) begin
        ln = snp_val;
        exp_from_snp = 1'b1;
        if (!exp_evict) exp_lat = 4;
      end else begin
        ln = mem[exp_line];
      end
      exp_rdata = word_of(ln, off);
      exp_wdata = w ? with_word(ln, off, wd) : ln;
      exp_dirty = w | exp_from_snp;
    end
  endtask

  // ---------------- per-cycle compare process ----------------
  logic [15:0]  last_rdata;
  logic [63:0]  last_wr_data;
  logic         last_wdirty;
  logic [10:0]  last_ev_addr;
  logic [63:0]  last_ev_data;
  int unsigned  last_lat;
  int unsigned  n_mem_re = 0;

  initial begin
    logic pending;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        pending = (n_issued != n_done + n_aband);
        chk("re_we_exclusive", 64'(c_re & c_we), 64'd0);
        chk("cpu_stall", 64'(cpu_stall), 64'(pending && (cyc > t0) && !cpu_done));
        if (cpu_done) begin
          chk("done_has_request", 64'(pending), 64'd1);
          if (pending) begin
            last_lat = cyc - t0;
            if (exp_lat != 0) chk("latency", 64'(cyc - t0), 64'(exp_lat));
            if (exp_read) chk("cpu_rdata", 64'(cpu_rdata), 64'(exp_rdata));
            chk("hit_cnt", 64'(hit_cnt), 64'(m_hit));
            chk("miss_cnt", 64'(miss_cnt), 64'(m_miss));
            last_rdata = cpu_rdata;
            n_done++;
          end
        end
        if (c_we) begin
          chk("c_addr", 64'(c_addr), 64'(exp_line));
          chk("c_wr_data", c_wr_data, exp_wdata);
          chk("c_wdirty", 64'(c_wdirty), 64'(exp_dirty));
          last_wr_data = c_wr_data;
          last_wdirty  = c_wdirty;
        end
        if (mem_we) begin
          chk("evict_expected", 64'(exp_evict), 64'd1);
          chk("evict_addr", 64'(mem_addr), 64'(exp_ev_addr));
          chk("evict_data", mem_wdata, exp_ev_data);
          last_ev_addr = mem_addr;
          last_ev_data = mem_wdata;
        end
        if (mem_re) begin
          chk("fill_expected", 64'(exp_hit | exp_from_snp), 64'd0);
          chk("fill_addr", 64'(mem_addr), 64'(exp_line));
          n_mem_re++;
        end
        if (snp_req) chk("snp_addr", 64'(snp_addr), 64'(exp_line));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_req(input logic [15:0] a, input logic w, input logic both,
                        input logic [15:0] wd, input logic drop);
    bit got;
    @(posedge clk);
    #1;
    predict(a, w, wd);
    t0        = cyc;
    cpu_addr  = a;
    cpu_wdata = wd;
    cpu_we    = w;
    cpu_re    = !w | both;
    n_issued++;
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(posedge clk);
      #1;
      if (drop) begin
        cpu_re    = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 16'($urandom);
        cpu_wdata = 16'($urandom);
      end
      if (cpu_done) got = 1'b1;
    end
    cpu_re = 1'b0;
    cpu_we = 1'b0;
    chk("done_within_budget", 64'(got), 64'd1);
    @(negedge clk);
    #1;
  endtask

  task automatic check_zero(input string p);
    chk({p, "_ctl"}, 64'({cpu_done, cpu_stall, c_re, c_we, c_wdirty, snp_req, mem_re, mem_we}), 64'd0);
    chk({p, "_rdata"}, 64'(cpu_rdata), 64'd0);
    chk({p, "_addrs"}, 64'({c_addr, snp_addr, mem_addr}), 64'd0);
    chk({p, "_c_wr_data"}, c_wr_data, 64'd0);
    chk({p, "_mem_wdata"}, mem_wdata, 64'd0);
    chk({p, "_cnts"}, 64'({hit_cnt, miss_cnt}), 64'd0);
  endtask

  initial begin
    int unsigned snap;
    bit got;
    rst_n = 1'b0;
    cpu_re = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    snp_en = 1'b0;
    snp_val = '0;
    m_hit = '0;
    m_miss = '0;
    t0 = 0;
    exp_line = '0; exp_hit = 1'b0; exp_read = 1'b0; exp_evict = 1'b0;
    exp_ev_addr = '0; exp_ev_data = '0; exp_from_snp = 1'b0;
    exp_wdata = '0; exp_dirty = 1'b0; exp_rdata = '0; exp_lat = 0;
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // cold read, filled from memory
    snap = n_mem_re;
    do_req(16'h0104, 1'b0, 1'b0, 16'h0000, 1'b0);
    chk("t1_model_rdata", 64'(exp_rdata), 64'h4444);
    chk("t1_rdata", 64'(last_rdata), 64'h4444);
    chk("t1_miss_cnt", 64'(miss_cnt), 64'd1);
    chk("t1_wdirty", 64'(last_wdirty), 64'd0);
    chk("t1_filled", 64'(n_mem_re > snap), 64'd1);

    // same read hits
    do_req(16'h0104, 1'b0, 1'b0, 16'h0000, 1'b0);
    chk("t2_rdata", 64'(last_rdata), 64'h4444);
    chk("t2_hit_cnt", 64'(hit_cnt), 64'd1);
    chk("t2_latency", 64'(last_lat), 64'd2);

    // write hit to word 1
    do_req(16'h0105, 1'b1, 1'b0, 16'hBEEF, 1'b0);
    chk("t3_wr_data", last_wr_data, 64'h1111_2222_BEEF_4444);
    chk("t3_wdirty", 64'(last_wdirty), 64'd1);
    chk("t3_latency", 64'(last_lat), 64'd3);

    // conflicting read evicts the dirty line
    snap = n_mem_re;
    do_req(16'h1104, 1'b0, 1'b0, 16'h0000, 1'b0);
    chk("t4_ev_addr", 64'(last_ev_addr), 64'h041);
    chk("t4_ev_data", last_ev_data, 64'h1111_2222_BEEF_4444);
    chk("t4_filled", 64'(n_mem_re > snap), 64'd1);

    // miss served by the other core's cache
    snp_en  = 1'b1;
    snp_val = 64'hAAAA_BBBB_CCCC_DDDD;
    snap = n_mem_re;
    do_req(16'h0A0E, 1'b0, 1'b0, 16'h0000, 1'b0);
    chk("t5_rdata", 64'(last_rdata), 64'hBBBB);
    chk("t5_wdirty", 64'(last_wdirty), 64'd1);
    chk("t5_no_fill", 64'(n_mem_re - snap), 64'd0);
    chk("t5_latency", 64'(last_lat), 64'd4);
    chk("t5_miss_cnt", 64'(miss_cnt), 64'd3);

    // reset while waiting on a fill
    snp_en = 1'b0;
    @(posedge clk);
    #1;
    predict(16'h0210, 1'b0, 16'h0000);
    t0 = cyc;
    cpu_addr = 16'h0210;
    cpu_re = 1'b1;
    n_issued++;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(posedge clk);
      #1;
      if (mem_re) got = 1'b1;
    end
    chk("t6_reached_fill", 64'(got), 64'd1);
    #2;
    n_aband++;
    rst_n = 1'b0;
    cpu_re = 1'b0;
    #1;
    check_zero("mid_reset");
    m_hit = '0;
    m_miss = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    snap = n_done;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_no_done_after_reset", 64'(cpu_done), 64'd0);
    chk("t6_no_completion", 64'(n_done - snap), 64'd0);
    do_req(16'h0210, 1'b0, 1'b0, 16'h0000, 1'b0);
    chk("t7_miss_cnt", 64'(miss_cnt), 64'd1);
    chk("t7_hit_cnt", 64'(hit_cnt), 64'd0);

    // randomized traffic over a small address pool
    for (int n = 0; n < 300; n++) begin
      logic [15:0] a;
      logic        w;
      a = 16'(($urandom_range(0, 7) << 13) | ($urandom_range(0, 3) << 8) |
              ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      w = ($urandom_range(0, 1) == 1);
      snp_en  = ($urandom_range(0, 2) == 0);
      snp_val = {$urandom, $urandom};
      do_req(a, w, w && ($urandom_range(0, 3) == 0), 16'($urandom),
             ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    chk("final_hit_cnt", 64'(hit_cnt), 64'(m_hit));
    chk("final_miss_cnt", 64'(miss_cnt), 64'(m_miss));

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
